// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32_cpu memory/writeback stage: FSM state encoding and load
// width codes.
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] WIDTH_BYTE  = 2'd0;
  localparam logic [1:0] WIDTH_HWORD = 2'd1;
  localparam logic [1:0] WIDTH_WORD  = 2'd2;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load aligner: selects the addressed byte/halfword lane of a read word and
// sign- or zero-extends it to 32 bits.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  width_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;
  logic        sign_bit;

  always_comb begin
    lane     = data_i >> {offset_i, 3'b000};
    sign_bit = 1'b0;
    data_o   = lane;
    case (width_i)
      WIDTH_BYTE: begin
        sign_bit = lane[7] & ~unsigned_i;
        data_o   = {{24{sign_bit}}, lane[7:0]};
      end
      WIDTH_HWORD: begin
        sign_bit = lane[15] & ~unsigned_i;
        data_o   = {{16{sign_bit}}, lane[15:0]};
      end
      // Width code 3 behaves as a full word.
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_wb.sv
// Memory-access and writeback stage: runs one load/store at a time on a wait-stated bus,
// aligns load data and drives the register-file write port.
module rv32i_mem_wb
  import rv32i_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_c,
  input  logic        alu_load,
  input  logic        alu_store,
  input  logic [31:0] alu_addr,
  input  logic [3:0]  alu_st_be,
  input  logic [1:0]  alu_ld_width,
  input  logic        alu_ld_unsigned,
  input  logic [1:0]  alu_ld_offset,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_error
);

  localparam logic [7:0] TimeoutCnt = 8'(RD_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  width_q, width_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        bus_error_q, bus_error_d;

  logic [31:0] aligned;
  logic        timeout;

  rv32i_load_align u_load_align (
    .data_i     (mem_readdata),
    .offset_i   (off_q),
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .data_o     (aligned)
  );

  assign timeout = (cnt_q + 8'd1) == TimeoutCnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (alu_load) begin
          state_d = RD_REQ;
        end else if (alu_store) begin
          state_d = WR_REQ;
        end
      end
      WR_REQ:  if (!mem_waitrequest) state_d = IDLE;
      RD_REQ:  if (!mem_waitrequest) state_d = RD_WAIT;
      RD_WAIT: if (mem_readdatavalid || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    width_d     = width_q;
    uns_d       = uns_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu_load) begin
          addr_d     = alu_addr;
          be_d       = 4'b1111;
          rd_d       = alu_rd;
          width_d    = alu_ld_width;
          uns_d      = alu_ld_unsigned;
          off_d      = alu_ld_offset;
          mem_read_d = 1'b1;
        end else if (alu_store) begin
          addr_d      = alu_addr;
          be_d        = alu_st_be;
          wdata_d     = alu_c;
          mem_write_d = 1'b1;
        end else if (alu_rd != 5'd0) begin
          wb_we_d   = 1'b1;
          wb_rd_d   = alu_rd;
          wb_data_d = alu_c;
        end
      end
      WR_REQ: mem_write_d = mem_waitrequest;
      RD_REQ: begin
        mem_read_d = mem_waitrequest;
        if (!mem_waitrequest) cnt_d = 8'd0;
      end
      RD_WAIT: begin
        if (mem_readdatavalid) begin
          if (rd_q != 5'd0) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = aligned;
          end
        end else begin
          cnt_d       = cnt_q + 8'd1;
          bus_error_d = timeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      width_q     <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      width_q     <= width_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign stall          = (state_q != IDLE);
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign wb_we          = wb_we_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign bus_error      = bus_error_q;

endmodule
